// File: rtl/op_centric_queue_pkg.sv
// Shared types for the operation-centric queue: the per-cycle operation
// classification used by the top-level control logic.
package op_centric_queue_pkg;

   // Operation actually performed in a cycle, after the ready gating.
   typedef enum logic [1:0] {
      OP_IDLE = 2'b00,
      OP_PUSH = 2'b01,
      OP_POP  = 2'b10,
      OP_BOTH = 2'b11
   } queue_op_e;

   // Combine the accepted push and pop strobes into a single operation code.
   function automatic queue_op_e decode_op(input logic push_ok, input logic pop_ok);
      queue_op_e op;
      unique case ({pop_ok, push_ok})
         2'b01:   op = OP_PUSH;
         2'b10:   op = OP_POP;
         2'b11:   op = OP_BOTH;
         default: op = OP_IDLE;
      endcase
      return op;
   endfunction

endpackage : op_centric_queue_pkg

// File: rtl/op_centric_queue_storage.sv
// Entry storage for the queue: a plain register array with one synchronous
// write port and one combinational read port. Contents are never reset.
module op_centric_queue_storage
   import op_centric_queue_pkg::*;
#(
   parameter int unsigned p_depth    = 32,
   parameter int unsigned p_bitwidth = 32,
   parameter int unsigned p_addr_w   = 5
) (
   input  logic                  clk,
   input  logic                  wen,
   input  logic [p_addr_w-1:0]   waddr,
   input  logic [p_bitwidth-1:0] wdata,
   input  logic [p_addr_w-1:0]   raddr,
   output logic [p_bitwidth-1:0] rdata
);

   logic [p_bitwidth-1:0] mem_q [p_depth];

   // Write the addressed entry when the top level accepts a push.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem_q[waddr] <= wdata;
      end
   end

   // The read address is always a valid head pointer, so no range guard.
   assign rdata = mem_q[raddr];

endmodule : op_centric_queue_storage

// File: rtl/op_centric_queue.sv
// Synchronous FIFO with a push-back port and a pop-front port. Holds the
// head/tail pointers, occupancy count, ready flags and the registered
// pop result; entries live in op_centric_queue_storage.
module op_centric_queue
   import op_centric_queue_pkg::*;
#(
   parameter int unsigned p_depth    = 32,
   parameter int unsigned p_bitwidth = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push_back_en,
   output logic                  push_back_rdy,
   input  logic [p_bitwidth-1:0] push_back_data,
   input  logic                  pop_front_en,
   output logic                  pop_front_rdy,
   output logic [p_bitwidth-1:0] pop_front_data
);

   localparam int unsigned PTR_W = $clog2(p_depth);
   localparam int unsigned CNT_W = $clog2(p_depth + 1);

   // Pointers wrap by explicit compare so non-power-of-two depths work.
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(p_depth - 1);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(p_depth);

   logic [PTR_W-1:0]      head_q, head_d;
   logic [PTR_W-1:0]      tail_q, tail_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [p_bitwidth-1:0] data_q, data_d;

   logic                  push_ok;
   logic                  pop_ok;
   queue_op_e             op;
   logic [p_bitwidth-1:0] head_data;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   // Ready flags come from the registered count only, never from the enables.
   assign push_back_rdy = (count_q != FULL_CNT);
   assign pop_front_rdy = (count_q != '0);

   // A push while full or a pop while empty is simply not accepted; there is
   // no bypass from the push port to the pop port.
   assign push_ok = push_back_en && push_back_rdy;
   assign pop_ok  = pop_front_en && pop_front_rdy;
   assign op      = decode_op(push_ok, pop_ok);

   op_centric_queue_storage #(
      .p_depth    (p_depth),
      .p_bitwidth (p_bitwidth),
      .p_addr_w   (PTR_W)
   ) u_storage (
      .clk   (clk),
      .wen   (push_ok),
      .waddr (tail_q),
      .wdata (push_back_data),
      .raddr (head_q),
      .rdata (head_data)
   );

   // Next-state for pointers, count and pop result, selected by the operation.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      data_d  = data_q;
      unique case (op)
         OP_PUSH: begin
            tail_d  = ptr_inc(tail_q);
            count_d = count_q + 1'b1;
         end
         OP_POP: begin
            head_d  = ptr_inc(head_q);
            count_d = count_q - 1'b1;
            data_d  = head_data;
         end
         OP_BOTH: begin
            // Count is unchanged; the popped value is the old head.
            head_d  = ptr_inc(head_q);
            tail_d  = ptr_inc(tail_q);
            data_d  = head_data;
         end
         default: begin
         end
      endcase
   end

   // State register; reset (active-low) wins over any push or pop.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         data_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         data_q  <= data_d;
      end
   end

   assign pop_front_data = data_q;

endmodule : op_centric_queue

// File: tb/tb_op_centric_queue.sv
// Directed bench for op_centric_queue with three instances (8x8, 16x16, 32x32).
module tb_op_centric_queue;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic        a_pe, a_pr, a_oe, a_or;
   logic [7:0]  a_pd, a_od;
   logic        b_pe, b_pr, b_oe, b_or;
   logic [15:0] b_pd, b_od;
   logic        c_pe, c_pr, c_oe, c_or;
   logic [31:0] c_pd, c_od;

   op_centric_queue #(.p_depth(8), .p_bitwidth(8)) dut_a (
      .clk(clk), .rst(rst),
      .push_back_en(a_pe), .push_back_rdy(a_pr), .push_back_data(a_pd),
      .pop_front_en(a_oe), .pop_front_rdy(a_or), .pop_front_data(a_od));

   op_centric_queue #(.p_depth(16), .p_bitwidth(16)) dut_b (
      .clk(clk), .rst(rst),
      .push_back_en(b_pe), .push_back_rdy(b_pr), .push_back_data(b_pd),
      .pop_front_en(b_oe), .pop_front_rdy(b_or), .pop_front_data(b_od));

   op_centric_queue #(.p_depth(32), .p_bitwidth(32)) dut_c (
      .clk(clk), .rst(rst),
      .push_back_en(c_pe), .push_back_rdy(c_pr), .push_back_data(c_pd),
      .pop_front_en(c_oe), .pop_front_rdy(c_or), .pop_front_data(c_od));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Each operation task drives at a falling edge, lets one rising edge pass,
   // and returns at the next falling edge, where outputs are sampled.
   task automatic op_a(input logic push, input logic pop, input logic [7:0] d);
      @(negedge clk); a_pe = push; a_oe = pop; a_pd = d;
      @(negedge clk); a_pe = 1'b0; a_oe = 1'b0;
      $display("A push=%0b pop=%0b din=%h -> dout=%h prdy=%0b ordy=%0b", push, pop, d, a_od, a_pr, a_or);
   endtask

   task automatic op_b(input logic push, input logic pop, input logic [15:0] d);
      @(negedge clk); b_pe = push; b_oe = pop; b_pd = d;
      @(negedge clk); b_pe = 1'b0; b_oe = 1'b0;
      $display("B push=%0b pop=%0b din=%h -> dout=%h prdy=%0b ordy=%0b", push, pop, d, b_od, b_pr, b_or);
   endtask

   task automatic op_c(input logic push, input logic pop, input logic [31:0] d);
      @(negedge clk); c_pe = push; c_oe = pop; c_pd = d;
      @(negedge clk); c_pe = 1'b0; c_oe = 1'b0;
      $display("C push=%0b pop=%0b din=%h -> dout=%h prdy=%0b ordy=%0b", push, pop, d, c_od, c_pr, c_or);
   endtask

   logic [7:0] bytes [8];

   initial begin
      rst = 1'b0;
      a_pe = 0; a_oe = 0; a_pd = '0;
      b_pe = 0; b_oe = 0; b_pd = '0;
      c_pe = 0; c_oe = 0; c_pd = '0;

      // Reset for two cycles, then release.
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst8_push_rdy", {31'd0, a_pr}, 32'd1);
      check("rst8_pop_rdy", {31'd0, a_or}, 32'd0);
      check("rst8_data", {24'd0, a_od}, 32'd0);
      check("rst16_push_rdy", {31'd0, b_pr}, 32'd1);
      check("rst16_pop_rdy", {31'd0, b_or}, 32'd0);
      check("rst16_data", {16'd0, b_od}, 32'd0);
      check("rst32_push_rdy", {31'd0, c_pr}, 32'd1);
      check("rst32_pop_rdy", {31'd0, c_or}, 32'd0);
      check("rst32_data", c_od, 32'd0);

      // Fill depth 8 with random bytes and random gaps.
      for (int i = 0; i < 8; i++) begin
         bytes[i] = 8'($urandom);
         #($urandom_range(0, 100));
         op_a(1'b1, 1'b0, bytes[i]);
         check("fill_pop_rdy", {31'd0, a_or}, 32'd1);
         check("fill_push_rdy", {31'd0, a_pr}, (i == 7) ? 32'd0 : 32'd1);
      end
      repeat (3) @(negedge clk);
      check("full_idle_push_rdy", {31'd0, a_pr}, 32'd0);
      op_a(1'b1, 1'b0, 8'h5A);
      check("push_when_full_rdy", {31'd0, a_pr}, 32'd0);
      check("push_when_full_data", {24'd0, a_od}, 32'd0);

      // Drain in order; the ignored ninth push must not appear.
      for (int i = 0; i < 8; i++) begin
         op_a(1'b0, 1'b1, 8'h00);
         check("drain_data", {24'd0, a_od}, {24'd0, bytes[i]});
         check("drain_pop_rdy", {31'd0, a_or}, (i == 7) ? 32'd0 : 32'd1);
      end
      check("drain_push_rdy", {31'd0, a_pr}, 32'd1);
      repeat (2) @(negedge clk);
      op_a(1'b0, 1'b1, 8'h00);
      check("pop_empty_holds", {24'd0, a_od}, {24'd0, bytes[7]});

      // Full queue with simultaneous push and pop: pop taken, push ignored.
      for (int i = 0; i < 8; i++) op_a(1'b1, 1'b0, 8'(8'h40 + i));
      op_a(1'b1, 1'b1, 8'h77);
      check("full_both_data", {24'd0, a_od}, 32'h40);
      check("full_both_push_rdy", {31'd0, a_pr}, 32'd1);
      for (int i = 1; i < 8; i++) op_a(1'b0, 1'b1, 8'h00);
      check("full_both_last", {24'd0, a_od}, 32'h47);
      check("full_both_empty", {31'd0, a_or}, 32'd0);

      // Wrap on depth 16.
      for (int i = 1; i <= 10; i++) op_b(1'b1, 1'b0, 16'(i));
      for (int i = 1; i <= 6; i++) begin
         op_b(1'b0, 1'b1, 16'h0);
         check("wrap_first", {16'd0, b_od}, 32'(i));
      end
      for (int i = 11; i <= 20; i++) op_b(1'b1, 1'b0, 16'(i));
      for (int i = 7; i <= 20; i++) begin
         op_b(1'b0, 1'b1, 16'h0);
         check("wrap_second", {16'd0, b_od}, 32'(i));
      end
      check("wrap_empty", {31'd0, b_or}, 32'd0);

      // Empty queue with simultaneous push and pop: no bypass.
      op_b(1'b1, 1'b1, 16'hBEEF);
      check("empty_both_hold", {16'd0, b_od}, 32'h14);
      check("empty_both_rdy", {31'd0, b_or}, 32'd1);
      op_b(1'b0, 1'b1, 16'h0);
      check("empty_both_later", {16'd0, b_od}, 32'hBEEF);

      // Simultaneous push and pop on depth 32 with five entries.
      for (int i = 0; i < 5; i++) op_c(1'b1, 1'b0, 32'(32'h10 + i));
      op_c(1'b1, 1'b1, 32'h99);
      check("both_data", c_od, 32'h10);
      for (int i = 1; i <= 4; i++) begin
         op_c(1'b0, 1'b1, 32'h0);
         check("both_follow", c_od, 32'(32'h10 + i));
      end
      check("both_count_rdy", {31'd0, c_or}, 32'd1);
      op_c(1'b0, 1'b1, 32'h0);
      check("both_fifth", c_od, 32'h99);
      check("both_empty", {31'd0, c_or}, 32'd0);

      // Reset mid-operation with three entries, push asserted during reset.
      for (int i = 0; i < 3; i++) op_c(1'b1, 1'b0, 32'(32'h21 + i));
      op_c(1'b0, 1'b1, 32'h0);
      check("pre_reset_data", c_od, 32'h21);
      @(negedge clk); rst = 1'b0; c_pe = 1'b1; c_pd = 32'hDEAD;
      @(negedge clk); rst = 1'b1; c_pe = 1'b0;
      check("midrst_pop_rdy", {31'd0, c_or}, 32'd0);
      check("midrst_data", c_od, 32'd0);
      check("midrst_push_rdy", {31'd0, c_pr}, 32'd1);
      op_c(1'b1, 1'b0, 32'hAB);
      op_c(1'b0, 1'b1, 32'h0);
      check("midrst_ab", c_od, 32'hAB);
      check("midrst_empty", {31'd0, c_or}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_op_centric_queue

// File: doc/op_centric_queue.md
# op_centric_queue

Parameterized synchronous FIFO with operation-centric ports: a push-back port and a pop-front port, each with its own enable/ready pair. Storage is `p_depth` entries of `p_bitwidth` bits. Popped data is returned in a register that updates on the pop clock edge and then holds its value. The block is a generic buffering primitive used between single-clock producer and consumer logic.

## Interface
- `p_depth`, default 32: number of entries; must be ≥ 2; any integer, power of two not required.
- `p_bitwidth`, default 32: data width in bits; must be ≥ 1.

- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst`  in  1: reset; synchronous, active-low.
- `push_back_en`  in  1: push request; sampled at the rising edge.
- `push_back_rdy`  out  1: queue can accept a push (not full).
- `push_back_data`  in  `p_bitwidth`: data to append; sampled with `push_back_en`.
- `pop_front_en`  in  1: pop request; sampled at the rising edge.
- `pop_front_rdy`  out  1: queue holds at least one entry (not empty).
- `pop_front_data`  out  `p_bitwidth`: registered result of the most recent accepted pop.

## Operation
- State:
  - entry array `mem[p_depth]`
  - head pointer and tail pointer, each `$clog2(p_depth)` bits
  - occupancy count, `$clog2(p_depth+1)` bits
  - `pop_front_data` register
- A push is accepted when `push_back_en && push_back_rdy`:
  - `mem[tail] <= push_back_data`
  - tail advances by 1
  - count increments.
- A pop is accepted when `pop_front_en && pop_front_rdy`:
  - `pop_front_data <= mem[head]`
  - head advances by 1
  - count decrements.
- Pointer wrap: a pointer equal to `p_depth-1` wraps to 0. Explicit compare is required; power-of-two overflow must not be relied on.
- `push_back_rdy = (count != p_depth)` and `pop_front_rdy = (count != 0)`. Both are combinational from registered count only; no combinational dependence on `*_en`.
- Push while full is ignored: no state change and no error. This holds even if a pop is accepted in the same cycle.
- Pop while empty is ignored: `pop_front_data` holds. This holds even if a push is accepted in the same cycle; there is no bypass.
- Simultaneous accepted push and pop (0 < count < p_depth):
  - both pointers advance
  - count is unchanged
  - `pop_front_data` receives the old head.
- `pop_front_data` holds its value across any number of idle cycles until the next accepted pop.
- Data values are passed through unmodified; there is no arithmetic on data.

## Timing
- Reset, when `rst == 0` at a rising edge:
  - head, tail and count are 0
  - `pop_front_data` is 0
  - `push_back_rdy` is 1
  - `pop_front_rdy` is 0.
- Memory contents are not reset.
- Reset has priority over push and pop in the same cycle. Reset mid-operation discards all contents.
- Push latency: an entry pushed at edge N sets `pop_front_rdy` after edge N (visible in cycle N+1) and is poppable at edge N+1.
- Pop latency: data appears on `pop_front_data` immediately after the accepted pop's edge. It is valid for sampling from the following falling edge onward.
- Ready updates:
  - `push_back_rdy` falls right after the edge that accepts the `p_depth`-th outstanding push.
  - `pop_front_rdy` falls right after the edge that pops the last entry.
- Single-cycle enable pulses are fully supported. Back-to-back enables every cycle sustain one operation per cycle.

## Structure
- No shared package is needed. Pointer and count widths are local `localparam`s derived with `$clog2`.
- One natural sub-module, `op_centric_queue_storage`:
  - register array with one write port (`wen`, `waddr`, `wdata`)
  - one combinational read port (`raddr` → `rdata`).
- The top level holds the pointers, count, ready logic and the `pop_front_data` register.

## Test plan
- Reset checks, for 8×8 (depth × width), 16×16 and 32×32:
  - assert `rst=0` for 2 cycles, then release
  - required: `push_back_rdy=1`, `pop_front_rdy=0`, `pop_front_data=0`.
- Fill, depth 8, width 8: push 8 random bytes with random 0–100 time-unit gaps.
  - required: `push_back_rdy=0` after the 8th push, and it stays 0 while idle.
  - required: a 9th push with `push_back_en=1` changes nothing.
- Drain, same configuration: pop 8 times.
  - required: each `pop_front_data` equals the pushed values in order.
  - required: `pop_front_rdy=0` after the 8th pop, and `pop_front_data` holds the 8th value.
- Wrap, depth 16:
  - push 0x0001..0x000A, pop 6, push 0x000B..0x0014, pop 14
  - required: values return as 0x0001..0x0014 in order across the pointer wrap.
- Simultaneous push and pop, depth 32 with 5 entries (0x10..0x14):
  - push 0x99 and pop in the same cycle
  - required: `pop_front_data=0x10`, count stays 5, 0x99 is popped 5th afterwards.
- Reset mid-operation: reset with 3 entries held.
  - required: `pop_front_rdy=0`, `pop_front_data=0`.
  - required: after a subsequent push of 0xAB and a pop, `pop_front_data` returns 0xAB.
